// File: rtl/kd_tree_root_driver.sv
// Command initiator for the root kd-tree node: feeds N_CENTERS centers, configures depth/ttl/axis,
// starts the sort and waits for completion, with one acknowledged command per step and per-wait timeouts.
module kd_tree_root_driver #(
  parameter int DATA_W    = 32,
  parameter int CMD_W     = 3,
  parameter int N_CENTERS = 7,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        ttl_in,
  input  logic [1:0]        axis_in,
  input  logic [DATA_W-1:0] center_in,
  input  logic              center_valid,
  output logic              center_ready,
  output logic [CMD_W-1:0]  command_to_top,
  output logic [DATA_W-1:0] data_to_top,
  output logic              alert_to_top,
  input  logic [CMD_W-1:0]  command_from_top,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [CMD_W-1:0] NOP           = CMD_W'(0);
  localparam logic [CMD_W-1:0] SET_CENTER    = CMD_W'(1);
  localparam logic [CMD_W-1:0] DEPTH_TTL     = CMD_W'(2);
  localparam logic [CMD_W-1:0] START_SORT    = CMD_W'(3);
  localparam logic [CMD_W-1:0] FEED_ACK      = CMD_W'(4);
  localparam logic [CMD_W-1:0] SEND_SORT_ACK = CMD_W'(5);
  localparam logic [CMD_W-1:0] SORT_DONE     = CMD_W'(6);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (N_CENTERS > 1) ? $clog2(N_CENTERS) : 1;
  localparam logic [TW-1:0] TMO      = TW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CENTERS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FEED_IDLE,
    S_FEED_ISSUE,
    S_FEED_WAIT,
    S_CFG_IDLE,
    S_CFG_WAIT,
    S_SORT_IDLE,
    S_SORT_WAIT,
    S_ERR
  } state_t;

  state_t            state, state_d;
  logic [IW-1:0]     idx, idx_d;
  logic [TW-1:0]     timer, timer_d;
  logic [7:0]        ttl_q, ttl_d;
  logic [1:0]        axis_q, axis_d;
  logic [CMD_W-1:0]  cmd_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] cfg_word;
  logic              alert_d, ready_d, done_d, busy_d, error_d;
  logic              line_nop, count_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    ttl_d    = ttl_q;
    axis_d   = axis_q;
    cmd_d    = command_to_top;
    data_d   = data_to_top;
    alert_d  = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy;
    error_d  = error;
    count_en = 1'b0;
    line_nop = (command_from_top == NOP);
    cfg_word = '0;
    cfg_word[9:0] = {axis_q, ttl_q};

    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          ttl_d   = ttl_in;
          axis_d  = axis_in;
          error_d = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = S_FEED_IDLE;
        end
      end
      S_FEED_IDLE: begin
        // a host stall on an idle line must never time out
        count_en = !line_nop;
        if (line_nop && center_valid) begin
          cmd_d   = SET_CENTER;
          data_d  = center_in;
          alert_d = 1'b1;
          ready_d = 1'b1;
          state_d = S_FEED_ISSUE;
        end
      end
      S_FEED_ISSUE: state_d = S_FEED_WAIT;
      S_FEED_WAIT: begin
        count_en = 1'b1;
        if (command_from_top == FEED_ACK) begin
          cmd_d  = NOP;
          data_d = '0;
          if (idx == LAST_IDX) begin
            state_d = S_CFG_IDLE;
          end else begin
            idx_d   = idx + IW'(1);
            state_d = S_FEED_IDLE;
          end
        end
      end
      S_CFG_IDLE: begin
        count_en = 1'b1;
        if (line_nop) begin
          cmd_d   = DEPTH_TTL;
          data_d  = cfg_word;
          alert_d = 1'b1;
          state_d = S_CFG_WAIT;
        end
      end
      S_CFG_WAIT: begin
        count_en = 1'b1;
        if (command_from_top == SEND_SORT_ACK) begin
          cmd_d   = NOP;
          data_d  = '0;
          state_d = S_SORT_IDLE;
        end
      end
      S_SORT_IDLE: begin
        count_en = 1'b1;
        if (line_nop) begin
          cmd_d   = START_SORT;
          data_d  = '0;
          alert_d = 1'b1;
          state_d = S_SORT_WAIT;
        end
      end
      S_SORT_WAIT: begin
        count_en = 1'b1;
        if (command_from_top == SORT_DONE) begin
          cmd_d   = NOP;
          data_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // timeout overrides any same-cycle progress
    if (count_en && (timer == TMO)) begin
      state_d = S_ERR;
      cmd_d   = NOP;
      data_d  = '0;
      alert_d = 1'b0;
      ready_d = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      error_d = 1'b1;
    end

    if (state_d != state) timer_d = '0;
    else if (count_en)    timer_d = timer + TW'(1);
    else                  timer_d = timer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx            <= '0;
      timer          <= '0;
      command_to_top <= NOP;
      data_to_top    <= '0;
      alert_to_top   <= 1'b0;
      center_ready   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      idx            <= idx_d;
      timer          <= timer_d;
      command_to_top <= cmd_d;
      data_to_top    <= data_d;
      alert_to_top   <= alert_d;
      center_ready   <= ready_d;
      busy           <= busy_d;
      done           <= done_d;
      error          <= error_d;
    end
  end

  // configuration operands are plain data and need no reset
  always_ff @(posedge clk) begin
    ttl_q  <= ttl_d;
    axis_q <= axis_d;
  end

endmodule

// File: tb/tb_kd_tree_root_driver.sv
// Scoreboard bench for kd_tree_root_driver: a behavioural root node answers commands, a monitor
// pops expected (command, data) pairs on every alert and checks hold/release and handshake rules.
module tb_kd_tree_root_driver;

  localparam int DATA_W    = 32;
  localparam int CMD_W     = 3;
  localparam int N_CENTERS = 3;
  localparam int TIMEOUT   = 15;

  localparam logic [2:0] NOP = 3'd0, SET_CENTER = 3'd1, DEPTH_TTL = 3'd2, START_SORT = 3'd3;
  localparam logic [2:0] FEED_ACK = 3'd4, SEND_SORT_ACK = 3'd5, SORT_DONE = 3'd6, BUSY = 3'd7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        ttl_in = '0;
  logic [1:0]        axis_in = '0;
  logic [DATA_W-1:0] center_in = '0;
  logic              center_valid = 1'b0;
  logic              center_ready;
  logic [CMD_W-1:0]  command_to_top;
  logic [DATA_W-1:0] data_to_top;
  logic              alert_to_top;
  logic [CMD_W-1:0]  command_from_top;
  logic              busy, done, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kd_tree_root_driver #(
    .DATA_W(DATA_W), .CMD_W(CMD_W), .N_CENTERS(N_CENTERS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .ttl_in(ttl_in), .axis_in(axis_in),
    .center_in(center_in), .center_valid(center_valid), .center_ready(center_ready),
    .command_to_top(command_to_top), .data_to_top(data_to_top), .alert_to_top(alert_to_top),
    .command_from_top(command_from_top), .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ack_of(input logic [2:0] c);
    case (c)
      SET_CENTER: return FEED_ACK;
      DEPTH_TTL:  return SEND_SORT_ACK;
      START_SORT: return SORT_DONE;
      default:    return NOP;
    endcase
  endfunction

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] host_q[$];

  int feed_hold = 1;
  int cfg_dly = 0;
  bit sort_hang = 1'b0;

  // root node model
  bit         m_pend = 1'b0, m_chain = 1'b0, m_hang = 1'b0;
  int         m_dly = 0, m_hold = 0;
  logic [2:0] m_code = NOP;
  initial begin
    command_from_top = NOP;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 0; m_chain = 0; m_hang = 0; m_dly = 0; m_hold = 0;
        command_from_top = NOP;
      end else begin
        if (m_hang) begin
          if (!sort_hang) begin
            m_hang = 0;
            command_from_top = NOP;
          end
        end else if (m_hold > 0) begin
          m_hold--;
          if (m_hold == 0) begin
            if (m_chain) begin
              m_chain = 0;
              command_from_top = SORT_DONE;
              m_hold = 1;
            end else begin
              command_from_top = NOP;
            end
          end
        end else if (m_pend) begin
          if (m_dly > 0) m_dly--;
          else begin
            m_pend = 0;
            case (m_code)
              SET_CENTER: begin command_from_top = FEED_ACK; m_hold = feed_hold; end
              DEPTH_TTL:  begin command_from_top = SEND_SORT_ACK; m_hold = 1; end
              START_SORT: begin
                command_from_top = BUSY;
                if (sort_hang) m_hang = 1;
                else begin m_hold = 2; m_chain = 1; end
              end
              default: ;
            endcase
          end
        end
        if (alert_to_top) begin
          m_pend = 1;
          m_code = command_to_top;
          m_dly  = (command_to_top == DEPTH_TTL) ? cfg_dly : 0;
        end
      end
    end
  end

  // host center stream
  int n_taken = 0;
  bit h_take = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      h_take = center_valid && center_ready;
      @(posedge clk);
      #1;
      if (h_take) begin
        n_taken++;
        void'(host_q.pop_front());
      end
      if (host_q.size() > 0) begin
        center_valid = 1'b1;
        center_in    = host_q[0];
      end else begin
        center_valid = 1'b0;
        center_in    = '0;
      end
    end
  end

  // monitor / scoreboard
  int         cyc = 0;
  bit         outst = 1'b0;
  logic [2:0] out_cmd = NOP, out_ack = NOP;
  int         done_cnt = 0, ready_cnt = 0, t_sort = 0, t_err = 0;
  logic       err_prev = 1'b0;
  exp_t       e;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        outst = 0;
        err_prev = 0;
        exp_q.delete();
      end else begin
        if (error && !err_prev) t_err = cyc;
        err_prev = error;
        if (error) outst = 0;
        if (alert_to_top) begin
          check("alert_line_idle", 64'(command_from_top), 64'(NOP));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL alert_unexpected: cmd=%0d data=0x%0h with no expected entry",
                     command_to_top, data_to_top);
          end else begin
            e = exp_q.pop_front();
            check("alert_cmd", 64'(command_to_top), 64'(e.cmd));
            check("alert_data", 64'(data_to_top), 64'(e.data));
          end
          if (command_to_top == START_SORT) t_sort = cyc;
          outst   = 1;
          out_cmd = command_to_top;
          out_ack = ack_of(command_to_top);
        end else if (outst) begin
          if (command_from_top == out_ack) begin
            check("ack_to_nop_cmd", 64'(command_to_top), 64'(NOP));
            check("ack_to_nop_data", 64'(data_to_top), 64'd0);
            outst = 0;
          end else begin
            check("cmd_held", 64'(command_to_top), 64'(out_cmd));
          end
        end
        if (center_ready) ready_cnt++;
        if (done) begin
          done_cnt++;
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic setup_run(input logic [7:0] ttl, input logic [1:0] ax,
                           input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
    exp_t x;
    ttl_in  = ttl;
    axis_in = ax;
    host_q.push_back(c0);
    host_q.push_back(c1);
    host_q.push_back(c2);
    x.cmd = SET_CENTER; x.data = c0; exp_q.push_back(x);
    x.data = c1; exp_q.push_back(x);
    x.data = c2; exp_q.push_back(x);
    x.cmd = DEPTH_TTL; x.data = {22'd0, ax, ttl}; exp_q.push_back(x);
    x.cmd = START_SORT; x.data = 32'd0; exp_q.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt < target; i++) @(posedge clk);
    #2;
    check("done_count", 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_cmd(input logic [2:0] c, input int max_cyc);
    for (int i = 0; i < max_cyc && command_to_top != c; i++) @(negedge clk);
    check("wait_cmd_seen", 64'(command_to_top), 64'(c));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_alert"}, 64'(alert_to_top), 64'd0);
    check({tag, "_ready"}, 64'(center_ready), 64'd0);
    check({tag, "_cmd"}, 64'(command_to_top), 64'(NOP));
    check({tag, "_data"}, 64'(data_to_top), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // run 1: immediate acks, ttl 5 / axis 2
    setup_run(8'h05, 2'd2, 32'h11, 32'h22, 32'h33);
    pulse_start();
    wait_done(1, 300);
    check("run1_ready_pulses", 64'(ready_cnt), 64'd3);
    check("run1_taken", 64'(n_taken), 64'd3);
    check("run1_busy", 64'(busy), 64'd0);
    check("run1_error", 64'(error), 64'd0);
    check("run1_exp_left", 64'(exp_q.size()), 64'd0);

    // run 2: held FEED_ACK, slow config ack, start pulsed during CFG_WAIT
    feed_hold = 4;
    cfg_dly = 6;
    setup_run(8'hA5, 2'd1, 32'h44, 32'h55, 32'h66);
    pulse_start();
    wait_cmd(DEPTH_TTL, 300);
    @(negedge clk);
    start = 1'b1;
    ttl_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("cfgwait_start_busy", 64'(busy), 64'd1);
    check("cfgwait_start_cmd", 64'(command_to_top), 64'(DEPTH_TTL));
    check("cfgwait_start_data", 64'(data_to_top), 64'h1A5);
    wait_done(2, 400);
    check("run2_ready_pulses", 64'(ready_cnt), 64'd6);
    check("run2_exp_left", 64'(exp_q.size()), 64'd0);

    // run 3: root answers BUSY forever -> timeout
    feed_hold = 1;
    cfg_dly = 0;
    sort_hang = 1'b1;
    setup_run(8'h3C, 2'd3, 32'h77, 32'h88, 32'h99);
    pulse_start();
    for (int i = 0; i < 400 && !error; i++) @(negedge clk);
    check("hang_error", 64'(error), 64'd1);
    check("hang_wait_cycles", 64'(t_err - t_sort), 64'd16);
    check("hang_busy", 64'(busy), 64'd0);
    check("hang_cmd", 64'(command_to_top), 64'(NOP));
    repeat (5) @(negedge clk);
    check("hang_error_sticky", 64'(error), 64'd1);
    sort_hang = 1'b0;
    repeat (3) @(negedge clk);
    setup_run(8'h01, 2'd0, 32'hAA, 32'hBB, 32'hCC);
    pulse_start();
    check("restart_error_clr", 64'(error), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    wait_done(3, 300);
    check("run3_ready_pulses", 64'(ready_cnt), 64'd12);
    check("run3_exp_left", 64'(exp_q.size()), 64'd0);

    // run 4: asynchronous reset while waiting for the sort
    sort_hang = 1'b1;
    setup_run(8'h80, 2'd1, 32'hDD, 32'hEE, 32'hF0);
    pulse_start();
    wait_cmd(START_SORT, 300);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sort_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_cmd", 64'(command_to_top), 64'(NOP));
    check("post_rst_ready_pulses", 64'(ready_cnt), 64'd15);
    check("post_rst_done_count", 64'(done_cnt), 64'd3);
    check("post_rst_host_left", 64'(host_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
